// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB bus constants and completer state encoding
package apb_pkg;

    localparam int APB_ADDR_W  = 9;
    localparam int APB_DATA_W  = 8;
    localparam int APB_SEL_BIT = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - flop array with one sync write port and one comb read port
module apb_slave_regfile #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic w_in_range;
    logic r_in_range;

    assign w_in_range = 32'(waddr) < DEPTH;
    assign r_in_range = 32'(raddr) < DEPTH;

    // Storage: cleared on reset, written only for in-range addresses
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && w_in_range) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    // Read port: out-of-range addresses read as zero
    always_comb begin
        rdata = '0;
        if (r_in_range) begin
            rdata = mem[raddr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer with wait states and error response over a flop memory
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

    apb_state_e        state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              capture;
    logic              we;
    logic              addr_err;
    logic [DATA_W-1:0] rdata;

    // Upper address bits select the completer upstream and are not decoded here
    logic [APB_ADDR_W-ADDR_W-1:0] unused_paddr;
    assign unused_paddr = paddr[APB_ADDR_W-1:ADDR_W];

    assign addr_err = {1'b0, addr_q} >= DEPTH_CMP;

    apb_slave_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .pclk   (pclk),
        .preset (preset),
        .we     (we),
        .waddr  (addr_q),
        .wdata  (wdata_q),
        .raddr  (addr_q),
        .rdata  (rdata)
    );

    // State, wait counter and setup-phase capture registers
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (capture) begin
                addr_q  <= paddr[ADDR_W-1:0];
                wr_q    <= pwrite;
                wdata_q <= pwdata;
            end
        end
    end

    // Next state, wait countdown and bus response; no response while deselected or in reset
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        we      = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        if (psel && preset) begin
            case (state)
                IDLE: begin
                    if (!penable) begin
                        capture = 1'b1;
                        cnt_n   = 4'(WAIT_STATES);
                        state_n = ACCESS;
                    end else begin
                        // Access phase without a setup: error out at once, stay idle
                        pready  = 1'b1;
                        pslverr = 1'b1;
                    end
                end
                ACCESS: begin
                    if (!penable) begin
                        // Master fell back to setup: restart the transfer
                        capture = 1'b1;
                        cnt_n   = 4'(WAIT_STATES);
                    end else if (cnt != 4'd0) begin
                        cnt_n = cnt - 4'd1;
                    end else begin
                        pready  = 1'b1;
                        pslverr = addr_err;
                        we      = wr_q && !addr_err;
                        if (!wr_q && !addr_err) begin
                            prdata = rdata;
                        end
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else begin
            state_n = IDLE;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - self-checking bench for apb_slave_mem
module tb_apb_slave_mem;

    localparam int NI = 3;
    int ws_of    [NI] = '{0, 3, 1};
    int depth_of [NI] = '{256, 256, 128};

    logic       pclk;
    logic       preset  [NI];
    logic       psel    [NI];
    logic       penable [NI];
    logic       pwrite  [NI];
    logic [8:0] paddr   [NI];
    logic [7:0] pwdata  [NI];
    logic [7:0] prdata  [NI];
    logic       pready  [NI];
    logic       pslverr [NI];

    logic [7:0] mem_m [NI][256];

    int n_cmp = 0;
    int n_bad = 0;

    apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0)) u0 (
        .pclk(pclk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

    apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(3)) u1 (
        .pclk(pclk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

    apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_STATES(1)) u2 (
        .pclk(pclk), .preset(preset[2]), .psel(psel[2]), .penable(penable[2]),
        .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]),
        .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        int         d;
        bit         wr;
        logic [8:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        bit         exp_err;
        bit         keep;
        bit         disturb;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference: word addressed by the low 8 bits, error when beyond the instance depth
    task automatic model_apply(input int d, input bit wr, input logic [8:0] addr,
                               input logic [7:0] data, output logic [7:0] rd, output logic err);
        int a;
        a   = int'(addr[7:0]);
        err = a >= depth_of[d];
        rd  = (wr || err) ? 8'h00 : mem_m[d][a];
        if (wr && !err) mem_m[d][a] = data;
    endtask

    task automatic model_clear(input int d);
        for (int a = 0; a < 256; a++) mem_m[d][a] = 8'h00;
    endtask

    // One transfer starting just after a rising edge; leaves psel high when keep is set
    task automatic xfer(input int d, input bit wr, input logic [8:0] addr, input logic [7:0] data,
                        input bit keep, input bit disturb,
                        output logic [7:0] rd, output logic err, output int waits);
        psel[d] = 1'b1; penable[d] = 1'b0;
        pwrite[d] = wr; paddr[d] = addr; pwdata[d] = data;
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        if (disturb) begin
            pwrite[d] = ~wr; paddr[d] = addr - 9'd1; pwdata[d] = ~data;
        end
        waits = 0;
        forever begin
            @(negedge pclk);
            if (pready[d]) break;
            check("wait_pslverr", pslverr[d], 0);
            check("wait_prdata", prdata[d], 0);
            waits++;
            if (waits > 20) begin
                check("timeout_pready", pready[d], 1);
                break;
            end
        end
        rd  = prdata[d];
        err = pslverr[d];
        @(posedge pclk); #1;
        penable[d] = 1'b0;
        if (!keep) psel[d] = 1'b0;
    endtask

    task automatic read_expect(input int d, input logic [8:0] addr, input logic [7:0] exp, input string nm);
        logic [7:0] rd, mrd;
        logic       err, merr;
        int         w;
        xfer(d, 1'b0, addr, 8'h00, 1'b0, 1'b0, rd, err, w);
        model_apply(d, 1'b0, addr, 8'h00, mrd, merr);
        check({nm, "_rd"}, rd, exp);
        check({nm, "_err"}, err, 0);
        check({nm, "_waits"}, w, ws_of[d]);
    endtask

    initial begin
        logic [7:0] rd, mrd;
        logic       err, merr;
        int         w, d, nd;
        bit         wr, keep;
        logic [8:0] addr;
        logic [7:0] data;

        for (int i = 0; i < NI; i++) begin
            preset[i] = 1'b0; psel[i] = 1'b0; penable[i] = 1'b0;
            pwrite[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
            model_clear(i);
        end

        // d, wr, addr, data, exp_rd, exp_err, keep, disturb
        vecs.push_back('{0, 1'b1, 9'h010, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b0, 9'h010, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 1'b1, 9'h010, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 1'b0, 9'h010, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 1'b1, 9'h020, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1, 1'b0, 9'h020, 8'h00, 8'hC3, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2, 1'b1, 9'h090, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{2, 1'b0, 9'h090, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{2, 1'b1, 9'h010, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2, 1'b0, 9'h010, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2, 1'b0, 9'h07F, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2, 1'b0, 9'h080, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b1, 9'h001, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{0, 1'b1, 9'h002, 8'h22, 8'h00, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{0, 1'b0, 9'h001, 8'h00, 8'h11, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{0, 1'b0, 9'h002, 8'h00, 8'h22, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b1, 9'h004, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{0, 1'b0, 9'h004, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b0, 9'h003, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b1, 9'h105, 8'h66, 8'h00, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b0, 9'h005, 8'h00, 8'h66, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{0, 1'b0, 9'h0FF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});

        // Reset state, sampled while reset is held and again after release
        repeat (3) @(posedge pclk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_pready%0d", i), pready[i], 0);
            check($sformatf("rst_pslverr%0d", i), pslverr[i], 0);
            check($sformatf("rst_prdata%0d", i), prdata[i], 0);
        end
        for (int i = 0; i < NI; i++) preset[i] = 1'b1;
        @(posedge pclk); #1;

        foreach (vecs[k]) begin
            xfer(vecs[k].d, vecs[k].wr, vecs[k].addr, vecs[k].data,
                 vecs[k].keep, vecs[k].disturb, rd, err, w);
            model_apply(vecs[k].d, vecs[k].wr, vecs[k].addr, vecs[k].data, mrd, merr);
            check($sformatf("vec%0d_rd", k), rd, vecs[k].exp_rd);
            check($sformatf("vec%0d_err", k), err, vecs[k].exp_err);
            check($sformatf("vec%0d_waits", k), w, ws_of[vecs[k].d]);
        end

        // Access phase with no setup: single-cycle error, completer stays idle
        psel[2] = 1'b1; penable[2] = 1'b1; pwrite[2] = 1'b1; paddr[2] = 9'h010; pwdata[2] = 8'hEE;
        #1;
        check("nosetup_pready", pready[2], 1);
        check("nosetup_pslverr", pslverr[2], 1);
        @(posedge pclk); #1;
        check("nosetup2_pready", pready[2], 1);
        check("nosetup2_pslverr", pslverr[2], 1);
        psel[2] = 1'b0; penable[2] = 1'b0;
        #1;
        check("desel_pready", pready[2], 0);
        check("desel_pslverr", pslverr[2], 0);
        @(posedge pclk); #1;
        read_expect(2, 9'h010, 8'h5A, "nosetup_mem");

        // Master regresses to setup mid-wait: second setup wins, full wait reload
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 9'h050; pwdata[1] = 8'h12;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(posedge pclk); #1;
        xfer(1, 1'b1, 9'h051, 8'h34, 1'b0, 1'b0, rd, err, w);
        model_apply(1, 1'b1, 9'h051, 8'h34, mrd, merr);
        check("regress_err", err, 0);
        check("regress_waits", w, 3);
        read_expect(1, 9'h050, 8'h00, "regress_old");
        read_expect(1, 9'h051, 8'h34, "regress_new");

        // psel dropped mid-wait: no response, no write
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 9'h030; pwdata[1] = 8'h77;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(posedge pclk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        #1;
        check("abort_pready", pready[1], 0);
        @(posedge pclk); #1;
        read_expect(1, 9'h030, 8'h00, "abort_mem");

        // Reset pulsed mid-wait: outputs drop at once, memory cleared, target not written
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 9'h040; pwdata[1] = 8'hAB;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(posedge pclk); #1;
        preset[1] = 1'b0;
        #1;
        check("midrst_pready", pready[1], 0);
        check("midrst_pslverr", pslverr[1], 0);
        check("midrst_prdata", prdata[1], 0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge pclk); #1;
        preset[1] = 1'b1;
        model_clear(1);
        @(posedge pclk); #1;
        read_expect(1, 9'h040, 8'h00, "midrst_target");
        read_expect(1, 9'h010, 8'h00, "midrst_cleared");

        // Randomised traffic against the reference memories
        d = $urandom_range(0, NI - 1);
        for (int i = 0; i < 200; i++) begin
            nd   = $urandom_range(0, NI - 1);
            wr   = 1'($urandom_range(0, 1));
            addr = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'b000, 4'($urandom_range(0, 15))};
            data = 8'($urandom);
            keep = (nd == d) && (i != 199) && ($urandom_range(0, 1) == 1);
            xfer(d, wr, addr, data, keep, 1'($urandom_range(0, 3) == 0), rd, err, w);
            model_apply(d, wr, addr, data, mrd, merr);
            check($sformatf("rnd%0d_rd", i), rd, mrd);
            check($sformatf("rnd%0d_err", i), err, merr);
            check($sformatf("rnd%0d_waits", i), w, ws_of[d]);
            d = nd;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer: flop-based byte memory answering transfers from the team's APB master.
- One instance sits behind each of the master's slave selects, psel1 and psel2. paddr[8] chooses between them upstream; this block decodes only paddr[ADDR_W-1:0].
- Inserts a parameterised number of wait states and flags out-of-range or mis-sequenced accesses with pslverr.

Parameters:
- ADDR_W, 8, address bits decoded from paddr.
- DATA_W, 8, data width.
- DEPTH, 256, number of words; must be at most 2**ADDR_W.
- WAIT_STATES, 0, access-phase cycles with pready low before completion; range 0..15.

Ports:
- pclk, input, 1, bus clock; all state updates on the rising edge.
- preset, input, 1, asynchronous active-low reset.
- psel, input, 1, select for this completer.
- penable, input, 1, access-phase strobe.
- pwrite, input, 1, 1 = write, 0 = read.
- paddr, input, 9, bus address; bit 8 is ignored here.
- pwdata, input, DATA_W, write data.
- prdata, output, DATA_W, read data.
- pready, output, 1, transfer completes in this cycle.
- pslverr, output, 1, error response; valid only while pready=1.

Behaviour:
- Clock and reset: one clock, pclk. Reset is asynchronous and active-low on preset.
- Reset values: state=IDLE, wait counter=0, captured address/direction/data=0, every memory word=0, prdata=0, pready=0, pslverr=0. Reset asserted mid-transfer aborts the transfer with no memory write.
- States: IDLE, ACCESS.
- IDLE, psel=1 and penable=0 (setup phase):
  - At the rising edge, capture addr_q=paddr[ADDR_W-1:0], wr_q=pwrite, wdata_q=pwdata.
  - Load cnt=WAIT_STATES and go to ACCESS.
- Capture rule: during the access phase, pwrite, paddr and pwdata are ignored; only the setup-phase capture is used. Masters that disturb these signals in the access phase therefore cannot corrupt the transfer.
- ACCESS, psel=1 and penable=1:
  - cnt!=0: pready=0; cnt decrements each cycle.
  - cnt==0: pready=1 combinationally in that cycle, so the total access-phase length is WAIT_STATES+1 cycles.
- Completion, at the edge where pready=1:
  - Write with no error: mem[addr_q]<=wdata_q.
  - Afterwards, psel=1 and penable=0 means a back-to-back setup: capture and re-enter ACCESS with no idle cycle. Otherwise go to IDLE.
- Read data: prdata=mem[addr_q] while pready=1 and wr_q=0; otherwise prdata=0. Read latency from the setup cycle is WAIT_STATES+1 cycles.
- pslverr=1 together with pready=1 when either of these holds:
  - addr_q>=DEPTH: the write is not committed and a read returns 0.
  - Protocol violation: psel=1 and penable=1 seen in IDLE with no setup. Complete immediately with pready=1, pslverr=1, no memory effect, and stay in IDLE.
- psel falls in ACCESS before completion: abort to IDLE, no write, pready=0.
- penable low while still in ACCESS with psel high (master regressed to setup): treat as a new setup, recapture and reload cnt.
- psel=0: pready=0, pslverr=0, prdata=0 regardless of state.
- Widths: cnt is 4 bits. Address comparison is unsigned, at ADDR_W+1 bits, so DEPTH=2**ADDR_W never flags an error.

Decomposition:
- Package apb_pkg holds:
  - state localparams IDLE=1'b0 and ACCESS=1'b1;
  - APB_ADDR_W=9 and APB_DATA_W=8;
  - the slave-select bit index 8.
- One sub-module, apb_slave_regfile: DEPTH x DATA_W flop array with async reset, one synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
- apb_slave_mem keeps the FSM, the wait counter and the error logic.

Test Plan:
- Reset then WAIT_STATES=0: write 0x5A to 0x10, then read 0x10 → each access phase lasts 1 cycle with pready=1; read returns prdata=0x5A, pslverr=0.
- WAIT_STATES=3: read 0x10 → pready low for 3 access cycles, high on the 4th with prdata=0x5A; write to 0x20 is committed only at the pready cycle.
- DEPTH=128: write 0xFF to 0x90, then read 0x90 → both complete with pslverr=1; read returns 0x00; a subsequent read of 0x10 is unaffected.
- Back-to-back: write 0x11→0x01, write 0x22→0x02, read 0x01, read 0x02, with psel held high → no IDLE cycles; reads return 0x11 and 0x22.
- Robustness:
  - pwrite flipped and paddr changed to 0x03 during the access phase of a write of 0x33 to 0x04 → mem[0x04]=0x33, mem[0x03] unchanged.
  - penable=1 with no setup → single-cycle completion with pready=1, pslverr=1.
- Aborts:
  - preset pulsed low mid-wait with WAIT_STATES=3 → outputs 0 immediately; the target word is not written; memory reads back 0 after reset.
  - psel dropped mid-wait → return to IDLE; no write.
